l2_sqrt: RTL and testbench

- Sequential integer square-root stage. It sits directly downstream of the sum-of-squares accumulator and turns its 20-bit accumulated sum into the L2 norm.
- Accepts one radicand per valid/ready handshake and computes floor(sqrt(x)) by a digit-by-digit (restoring) method, one result bit per clock.
- Presents root and remainder on a valid/ready output port with full backpressure.

---
 rtl/l2_sqrt.sv | 119 +++++++++++
 tb/tb_l2_sqrt.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/l2_sqrt.sv
// Sequential restoring integer square root: one root bit per clock, valid/ready in and out.
// Optional build macro L2_SQRT_ROUND_EN rounds out_root to nearest (out_rem stays the floor remainder).
module l2_sqrt #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = IN_W / 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_root,
  output logic [OUT_W:0]     out_rem
);

  localparam int unsigned REM_W = OUT_W + 2;
  localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((IN_W % 2) != 0 || IN_W < 2 || OUT_W != IN_W / 2) begin : g_bad_width
      $error("l2_sqrt: IN_W must be even and >= 2, OUT_W must equal IN_W/2");
    end
  endgenerate

  logic [1:0]       state_q, state_nx;
  logic [IN_W-1:0]  x_q;
  logic [OUT_W-1:0] root_q;
  logic [REM_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       pair;
  logic [REM_W-1:0] rem_sh, sub, trial, rem_nx;
  logic             ge;
  logic [OUT_W-1:0] root_nx, root_out;

  assign in_ready = (state_q == IDLE);

  // One restoring iteration: bring down the next bit pair and try subtracting 4*root+1.
  always_comb begin
    pair    = x_q[IN_W-1 -: 2];
    rem_sh  = REM_W'({rem_q, pair});
    sub     = {root_q, 2'b01};
    trial   = rem_sh - sub;
    ge      = (rem_sh >= sub);
    rem_nx  = ge ? trial : rem_sh;
    root_nx = (root_q << 1) | OUT_W'(ge);
`ifdef L2_SQRT_ROUND_EN
    // Round up when rem > root; saturate at the all-ones root.
    if ((rem_nx > REM_W'(root_nx)) && !(&root_nx))
      root_out = root_nx + OUT_W'(1);
    else
      root_out = root_nx;
`else
    root_out = root_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_nx = CALC;
      CALC:    if (cnt_q == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_root  <= '0;
      out_rem   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q    <= in_data;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= CNT_W'(OUT_W - 1);
          end
        end
        CALC: begin
          x_q    <= x_q << 2;
          root_q <= root_nx;
          rem_q  <= rem_nx;
          if (cnt_q == '0) begin
            out_root  <= root_out;
            out_rem   <= rem_nx[OUT_W:0];
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_sqrt.sv
// Scoreboard bench for l2_sqrt: accepts observed on the input port push expected results,
// an independent monitor checks latency, hold stability, in_ready and reset clearing.
module tb_l2_sqrt;

  localparam int unsigned IN_W  = 20;
  localparam int unsigned OUT_W = IN_W / 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_root;
  logic [OUT_W:0]   out_rem;

  l2_sqrt #(.IN_W(IN_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_root(out_root), .out_rem(out_rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x;
    longint root;
    longint rem;
    int     acc_cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   rand_ready = 1'b0;
  bit   rst_seen = 1'b0;
  bit   ov_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input longint x, input int acc);
    exp_t e;
    longint r = 0;
    longint maxr = (longint'(1) << OUT_W) - 1;
    while ((r + 1) * (r + 1) <= x) r++;
    e.x = x;
    e.rem = x - r * r;
    e.root = r;
`ifdef L2_SQRT_ROUND_EN
    if (e.rem > r && r < maxr) e.root = r + 1;
`endif
    e.acc_cyc = acc;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, predicting what the next rising edge does.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_root", longint'(out_root), 0);
      check("rst_out_rem", longint'(out_rem), 0);
      check("rst_in_ready", longint'(in_ready), 1);
      rst_seen = 1'b0;
    end
    if (!reset) begin
      q.delete();
      ov_seen = 1'b0;
      rst_seen = 1'b1;
    end else begin
      check("in_ready", longint'(in_ready), longint'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          if (!ov_seen) begin
            check("latency", longint'(cyc - q[0].acc_cyc), longint'(OUT_W));
            ov_seen = 1'b1;
          end
          check("out_root", longint'(out_root), q[0].root);
          check("out_rem", longint'(out_rem), q[0].rem);
          if (out_ready) begin
            void'(q.pop_front());
            ov_seen = 1'b0;
          end
        end
      end else if (ov_seen) begin
        check("out_valid_dropped", 0, 1);
        ov_seen = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(model(longint'(in_data), cyc + 1));
    end
  end

  task automatic send(input logic [IN_W-1:0] x);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && reset;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = IN_W'($urandom);
  endtask

  task automatic drain();
    int i = 0;
    while (q.size() != 0 && i < 1000) begin
      @(posedge clk); #1;
      i++;
    end
    if (q.size() != 0) check("drain_timeout", longint'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int i;
    logic [IN_W-1:0] xs [6] = '{20'd0, 20'd144, 20'd200, 20'd1048575, 20'd210, 20'd211};
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Directed values, back-to-back with out_ready high.
    foreach (xs[k]) send(xs[k]);
    drain();

    // Backpressure: hold result for 5 cycles with in_valid asserted meanwhile.
    out_ready = 1'b0;
    send(20'd200);
    i = 0;
    while (!out_valid && i < 100) begin @(posedge clk); #1; i++; end
    if (!out_valid) check("bp_wait_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = 20'd999;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset on the 4th CALC edge, then a fresh computation.
    send(20'd500);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send(20'd81);
    drain();

    // Random radicands with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       send(IN_W'($urandom_range(0, 300)));
        1:       send(IN_W'(((1 << IN_W) - 1) - $urandom_range(0, 3000)));
        default: send(IN_W'($urandom));
      endcase
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
